// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage RISC-V core: forwarding selects, load-use stall,
// multi-cycle branch flush and memory-handshake freeze. Counters enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int RF_ADDRESS  = 5,
  parameter int FWD_STAGES  = 2,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16,
  parameter int FSEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [RF_ADDRESS-1:0]            id_rs1,
  input  logic [RF_ADDRESS-1:0]            id_rs2,
  input  logic                             id_rs1_used,
  input  logic                             id_rs2_used,
  input  logic [RF_ADDRESS-1:0]            ex_rs1,
  input  logic [RF_ADDRESS-1:0]            ex_rs2,
  input  logic [RF_ADDRESS-1:0]            ex_rd,
  input  logic                             ex_memread,
  input  logic [FWD_STAGES*RF_ADDRESS-1:0] fwd_rd,
  input  logic [FWD_STAGES-1:0]            fwd_regwrite,
  input  logic                             br_taken,
  input  logic                             mem_req,
  input  logic                             mem_ready,
  output logic                             pc_en,
  output logic                             if_id_en,
  output logic                             if_id_flush,
  output logic                             id_ex_bubble,
  output logic                             ex_stall,
  output logic                             mem_wb_bubble,
  output logic [FSEL_W-1:0]                fwd_a_sel,
  output logic [FSEL_W-1:0]                fwd_b_sel,
  output logic [1:0]                       state,
  output logic [CNT_W-1:0]                 stall_cycles,
  output logic [CNT_W-1:0]                 flush_events
);

  localparam int FL_W = 4;

  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MEM_WAIT = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [FL_W-1:0] flush_left, flush_left_d;
  logic            freeze, load_use;

  assign freeze   = mem_req && !mem_ready;
  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
  assign state    = state_q;

  // Scan from the oldest stage down so the youngest matching producer wins.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    if (reset) begin
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
        if (fwd_regwrite[k] && ex_rs1 != '0 && fwd_rd[k*RF_ADDRESS +: RF_ADDRESS] == ex_rs1)
          fwd_a_sel = FSEL_W'(k + 1);
        if (fwd_regwrite[k] && ex_rs2 != '0 && fwd_rd[k*RF_ADDRESS +: RF_ADDRESS] == ex_rs2)
          fwd_b_sel = FSEL_W'(k + 1);
      end
    end
  end

  always_comb begin
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    if_id_flush   = 1'b1;
    id_ex_bubble  = 1'b1;
    ex_stall      = 1'b0;
    mem_wb_bubble = 1'b0;
    state_d       = state_q;
    flush_left_d  = flush_left;
    if (reset) begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      case (state_q)
        RUN: begin
          if (freeze) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            ex_stall      = 1'b1;
            mem_wb_bubble = 1'b1;
            flush_left_d  = '0;
            state_d       = MEM_WAIT;
          end else if (br_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_left_d = FL_W'(FLUSH_DEPTH - 1);
            state_d      = (FLUSH_DEPTH > 1) ? FLUSH : RUN;
          end else if (load_use) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        FLUSH: begin
          if (freeze) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            ex_stall      = 1'b1;
            mem_wb_bubble = 1'b1;
            state_d       = MEM_WAIT;
          end else begin
            if_id_flush  = 1'b1;
            flush_left_d = flush_left - FL_W'(1);
            if (flush_left <= FL_W'(1)) begin
              flush_left_d = '0;
              state_d      = RUN;
            end
          end
        end
        MEM_WAIT: begin
          // The release cycle advances the pipe normally; a pending branch waits for RUN.
          if (!mem_ready) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            ex_stall      = 1'b1;
            mem_wb_bubble = 1'b1;
          end else begin
            state_d = (flush_left != '0) ? FLUSH : RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      flush_left <= '0;
    end else begin
      state_q    <= state_d;
      flush_left <= flush_left_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic             br_acc;
  logic [CNT_W-1:0] stall_q, flush_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign br_acc = (state_q == RUN) && !freeze && br_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en) stall_q <= sat_inc(stall_q);
      if (br_acc) flush_q <= sat_inc(flush_q);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by randomized traffic,
// all compared against a cycle-level behavioural model of the control rules.
module tb_pipe_ctrl;

  localparam int RA   = 5;
  localparam int FS   = 4;
  localparam int FD   = 3;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [RA-1:0]   id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
  logic            id_rs1_used, id_rs2_used, ex_memread;
  logic [FS*RA-1:0] fwd_rd;
  logic [FS-1:0]   fwd_regwrite;
  logic            br_taken, mem_req, mem_ready;
  logic            pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_stall, mem_wb_bubble;
  logic [2:0]      fwd_a_sel, fwd_b_sel;
  logic [1:0]      state;
  logic [CW-1:0]   stall_cycles, flush_events;

  pipe_ctrl #(.RF_ADDRESS(RA), .FWD_STAGES(FS), .FLUSH_DEPTH(FD), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .fwd_rd(fwd_rd), .fwd_regwrite(fwd_regwrite), .br_taken(br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .ex_stall(ex_stall), .mem_wb_bubble(mem_wb_bubble),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .state(state),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: whether the pipe is frozen, how many squash cycles are still owed, counters.
  bit m_frozen;
  int m_pend, m_stall, m_flush;
  logic [31:0] e_pc, e_ifid, e_fl, e_bub, e_stl, e_mwb, e_fa, e_fb, e_st, e_sc, e_fe;
  bit e_frz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd_src(input logic [RA-1:0] rs);
    if (rs == 0) return 0;
    for (int k = 0; k < FS; k++)
      if (fwd_regwrite[k] && fwd_rd[k*RA +: RA] == rs) return k + 1;
    return 0;
  endfunction

  task automatic set_ctl(input bit pc, input bit ifid, input bit fl, input bit bub,
                         input bit stl, input bit mwb);
    e_pc = pc; e_ifid = ifid; e_fl = fl; e_bub = bub; e_stl = stl; e_mwb = mwb;
  endtask

  task automatic model_outputs();
    bit lu;
    lu = ex_memread && ex_rd != 0 &&
         ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    e_frz = reset && (m_frozen ? !mem_ready : (mem_req && !mem_ready));
    if (!reset)                set_ctl(0, 0, 1, 1, 0, 0);
    else if (e_frz)            set_ctl(0, 0, 0, 0, 1, 1);
    else if (m_frozen)         set_ctl(1, 1, 0, 0, 0, 0);
    else if (m_pend > 0)       set_ctl(1, 1, 1, 0, 0, 0);
    else if (br_taken)         set_ctl(1, 1, 1, 1, 0, 0);
    else if (lu)               set_ctl(0, 0, 0, 1, 0, 0);
    else                       set_ctl(1, 1, 0, 0, 0, 0);
    e_fa = reset ? fwd_src(ex_rs1) : 0;
    e_fb = reset ? fwd_src(ex_rs2) : 0;
    e_st = !reset ? 0 : m_frozen ? 2 : (m_pend > 0) ? 1 : 0;
    e_sc = PERF ? m_stall : 0;
    e_fe = PERF ? m_flush : 0;
  endtask

  task automatic model_update();
    if (!reset) begin
      m_frozen = 0; m_pend = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (e_pc == 0 && m_stall < CMAX) m_stall++;
      if (e_frz) m_frozen = 1;
      else if (m_frozen) m_frozen = 0;
      else if (m_pend > 0) m_pend--;
      else if (br_taken) begin
        m_pend = FD - 1;
        if (m_flush < CMAX) m_flush++;
      end
    end
  endtask

  // Called at a negedge with inputs applied: check outputs, cross the posedge, return at negedge.
  task automatic tick();
    #1;
    model_outputs();
    chk("pc_en", 32'(pc_en), e_pc);
    chk("if_id_en", 32'(if_id_en), e_ifid);
    chk("if_id_flush", 32'(if_id_flush), e_fl);
    chk("id_ex_bubble", 32'(id_ex_bubble), e_bub);
    chk("ex_stall", 32'(ex_stall), e_stl);
    chk("mem_wb_bubble", 32'(mem_wb_bubble), e_mwb);
    chk("fwd_a_sel", 32'(fwd_a_sel), e_fa);
    chk("fwd_b_sel", 32'(fwd_b_sel), e_fb);
    chk("state", 32'(state), e_st);
    chk("stall_cycles", 32'(stall_cycles), e_sc);
    chk("flush_events", 32'(flush_events), e_fe);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    id_rs1_used = 0; id_rs2_used = 0; ex_memread = 0;
    fwd_rd = '0; fwd_regwrite = '0; br_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 0;
    m_frozen = 0; m_pend = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    #1;
    chk("rst_pc_en", 32'(pc_en), 0);
    chk("rst_if_id_flush", 32'(if_id_flush), 1);
    tick();
    tick();
    reset = 1;
    tick();

    // Forwarding
    fwd_rd = {5'd0, 5'd0, 5'd5, 5'd5}; fwd_regwrite = 4'b0011; ex_rs1 = 5;
    #1 chk("fwd_a_x5", 32'(fwd_a_sel), 1);
    tick();
    ex_rs1 = 0;
    #1 chk("fwd_a_x0", 32'(fwd_a_sel), 0);
    tick();
    fwd_rd = {5'd9, 5'd0, 5'd0, 5'd0}; fwd_regwrite = 4'b1000; ex_rs2 = 9;
    #1 chk("fwd_b_stage3", 32'(fwd_b_sel), 4);
    tick();
    clear_inputs();

    // Load-use
    ex_memread = 1; ex_rd = 7; id_rs2 = 7; id_rs2_used = 1;
    #1 chk("lu_pc_en", 32'(pc_en), 0);
    tick();
    ex_memread = 0;
    tick();
    ex_memread = 1; id_rs2_used = 0;
    #1 chk("nolu_pc_en", 32'(pc_en), 1);
    tick();
    clear_inputs();

    // Branch flush
    br_taken = 1;
    #1 chk("br_bubble", 32'(id_ex_bubble), 1);
    tick();
    br_taken = 0;
    #1 chk("br_state1", 32'(state), 1);
    tick();
    #1 chk("br_state2", 32'(state), 1);
    tick();
    #1 chk("br_done", 32'(if_id_flush), 0);
    tick();

    // Freeze while one squash cycle is still owed
    br_taken = 1;
    tick();
    br_taken = 0;
    tick();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("frz_ex_stall", 32'(ex_stall), 1);
      tick();
    end
    mem_ready = 1;
    tick();
    mem_req = 0; mem_ready = 0;
    #1 chk("frz_resume_flush", 32'(state), 1);
    tick();
    tick();

    // Freeze, branch and load-use together
    br_taken = 1; ex_memread = 1; ex_rd = 3; id_rs1 = 3; id_rs1_used = 1;
    mem_req = 1; mem_ready = 0;
    #1 chk("combo_flush", 32'(if_id_flush), 0);
    tick();
    mem_ready = 1;
    #1 chk("combo_release_bub", 32'(id_ex_bubble), 0);
    tick();
    mem_req = 0; mem_ready = 0; ex_memread = 0;
    #1 chk("combo_branch", 32'(if_id_flush), 1);
    tick();
    clear_inputs();
    repeat (3) tick();

    // Asynchronous reset during MEM_WAIT
    mem_req = 1; mem_ready = 0;
    tick();
    #1 chk("mw_state", 32'(state), 2);
    reset = 0;
    #1 chk("arst_state", 32'(state), 0);
    chk("arst_pc_en", 32'(pc_en), 0);
    tick();
    mem_req = 0; reset = 1;
    tick();
    #1 chk("post_rst_state", 32'(state), 0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      id_rs1 = RA'($urandom_range(0, 3));  id_rs2 = RA'($urandom_range(0, 3));
      ex_rs1 = RA'($urandom_range(0, 3));  ex_rs2 = RA'($urandom_range(0, 3));
      ex_rd  = RA'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom_range(0, 1)); id_rs2_used = 1'($urandom_range(0, 1));
      ex_memread  = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < FS; k++) fwd_rd[k*RA +: RA] = RA'($urandom_range(0, 3));
      fwd_regwrite = FS'($urandom);
      br_taken  = ($urandom_range(0, 5) == 0);
      mem_req   = ($urandom_range(0, 3) == 0);
      mem_ready = 1'($urandom_range(0, 1));
      reset     = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the 5-stage RISC-V core. It produces operand-forwarding selects across a configurable number of downstream stages, the load-use stall, and a multi-cycle taken-branch flush. It also adds a full-pipeline freeze driven by a data-memory valid/ready handshake. Sits beside the datapath and drives the PC enable, the IF/ID, ID/EX and MEM/WB register controls, and the two EX-stage forwarding muxes.

## Interface
Parameters:
- RF_ADDRESS, 5, register index width
- FWD_STAGES, 2, forwarding source stages (1..4); index 0 = EX/MEM, 1 = MEM/WB, higher = later
- FLUSH_DEPTH, 2, fetch cycles squashed per taken branch (1..8)
- CNT_W, 16, performance counter width
- FSEL_W, $clog2(FWD_STAGES+1), forwarding select width (derived)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  RF_ADDRESS  source registers of the instruction in ID
- id_rs1_used, id_rs2_used  in  1  source register is actually read
- ex_rs1, ex_rs2  in  RF_ADDRESS  source registers of the instruction in EX
- ex_rd  in  RF_ADDRESS  destination register in EX
- ex_memread  in  1  EX instruction is a load
- fwd_rd  in  FWD_STAGES*RF_ADDRESS  destination of stage k at bits [k*RF_ADDRESS +: RF_ADDRESS]
- fwd_regwrite  in  FWD_STAGES  stage k writes the register file
- br_taken  in  1  taken branch or jump resolved in EX
- mem_req  in  1  MEM stage is issuing an access
- mem_ready  in  1  memory completes the access this cycle
- pc_en  out  1  PC load enable
- if_id_en  out  1  IF/ID load enable
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_bubble  out  1  load NOP into ID/EX
- ex_stall  out  1  hold ID/EX and EX/MEM contents
- mem_wb_bubble  out  1  load NOP into MEM/WB
- fwd_a_sel, fwd_b_sel  out  FSEL_W  0 = register file, k+1 = stage k
- state  out  2  RUN=0, FLUSH=1, MEM_WAIT=2
- stall_cycles, flush_events  out  CNT_W  performance counters (see Configuration)

## Operation
- Forwarding (combinational, all states): fwd_a_sel = k+1 for the smallest k with fwd_regwrite[k] && fwd_rd[k]==ex_rs1 && ex_rs1!=0; otherwise 0. fwd_b_sel is identical using ex_rs2.
- The freeze condition is mem_req && !mem_ready.
- Load-use condition: ex_memread && ex_rd!=0 && ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd)).
- Priority: freeze > branch flush > load-use.
- RUN:
  - Freeze: pc_en=0, if_id_en=0, ex_stall=1, mem_wb_bubble=1. Save the remaining flush count (0) and go to MEM_WAIT.
  - Else br_taken: pc_en=1, if_id_flush=1, id_ex_bubble=1, and flush_left<=FLUSH_DEPTH-1. Go to FLUSH if FLUSH_DEPTH>1.
  - Else load-use: pc_en=0, if_id_en=0, id_ex_bubble=1.
  - Else all enables 1, all bubbles/flushes 0.
- FLUSH:
  - if_id_flush=1, pc_en=1, br_taken and load-use ignored.
  - flush_left decrements each cycle. Return to RUN in the cycle flush_left reaches 1.
  - A freeze takes priority: flush_left holds and the state goes to MEM_WAIT.
- MEM_WAIT:
  - Freeze outputs are held while !mem_ready.
  - On mem_ready, release the freeze for that cycle. Return to FLUSH if flush_left!=0, else RUN.
  - A br_taken held by the frozen EX stage is serviced in RUN on the following cycle.

## Timing
- Forwarding selects, stall, bubble and flush outputs are Mealy: combinational from state and current inputs, and sampled by the pipeline registers at the same edge.
- state, flush_left and the counters are updated on the rising clk edge.
- Reset (asynchronous, active-low), effective immediately while low:
  - state=RUN, flush_left=0, counters=0.
  - Outputs: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_bubble=1, ex_stall=0, mem_wb_bubble=0, fwd_*_sel=0.
- Reset asserted mid-FLUSH or mid-MEM_WAIT abandons the operation. The unit resumes in RUN on the first edge after release.
- Branch penalty is exactly FLUSH_DEPTH squashed fetches plus the ID/EX bubble.
- A load-use stall lasts exactly 1 cycle.
- A freeze lasts exactly as many cycles as mem_ready is low, plus 0.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cycles increments on every cycle with reset high and pc_en==0.
  - flush_events increments on each br_taken acceptance in RUN.
  - Both counters saturate at 2^CNT_W-1.
- Not defined: both outputs are constant 0 and no counter flops are instantiated.

## Test plan
- fwd_rd={stage1:x5, stage0:x5}, both regwrite, ex_rs1=x5 -> fwd_a_sel=1. ex_rs1=x0 -> 0. FWD_STAGES=4 with only stage 3 matching -> 4.
- ex_memread=1, ex_rd=x7, id_rs2=x7, id_rs2_used=1 -> one cycle of pc_en=0 and id_ex_bubble=1. Same case with id_rs2_used=0 -> no stall.
- FLUSH_DEPTH=3, br_taken pulse -> if_id_flush high 3 cycles, id_ex_bubble high 1 cycle, state 0→1→1→0, flush_events=1.
- mem_req=1 with mem_ready low 4 cycles during FLUSH (flush_left=1) -> 4 freeze cycles, ex_stall=1, then 1 FLUSH cycle, then RUN. stall_cycles=4 with PERF.
- br_taken, load-use and freeze asserted together -> freeze outputs only. On mem_ready, the branch is flushed next cycle and the load-use is not applied.
- Reset driven low during MEM_WAIT -> outputs immediately at reset values, state=0. After release the first edge behaves as RUN.
